// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI receive slave with CRC check.
package spi_pkg;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_SHIFT = 2'd1,
      R_WAIT  = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_RUN  = 2'd1,
      C_DONE = 2'd2
   } chk_state_t;

   localparam logic [3:0] DEFAULT_CRC4_POLY = 4'b0011;
   localparam logic [7:0] DEFAULT_CRC8_POLY = 8'h07;

   // Data is sampled on the rising sclk edge when CPOL and CPHA agree,
   // otherwise on the falling edge.
   function automatic bit sample_on_rise(input bit cpol, input bit cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/crc_div_serial.sv
// Iterative CRC long divider: one division step per clock over the
// payload bits, then a one-cycle done with the payload and remainder flag.
//
// state  | meaning
// C_IDLE | waiting for start
// C_RUN  | one XOR-subtract step per clock, bit W-1 down to CRC_W
// C_DONE | result visible for one cycle (done_o), may restart
module crc_div_serial
   import spi_pkg::*;
#(
   parameter int               W     = 12,
   parameter int               CRC_W = 4,
   parameter logic [CRC_W-1:0] POLY  = DEFAULT_CRC4_POLY
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [W-1:0]         codeword_i,
   output logic                 done_o,
   output logic                 busy_o,
   output logic [W-CRC_W-1:0]   data_o,
   output logic                 crc_err_o
);

   localparam int             DATA_W = W - CRC_W;
   localparam int             IDX_W  = $clog2(W);
   localparam logic [W-1:0]   GEN_W  = W'({1'b1, POLY});

   chk_state_t         state_q, state_d;
   logic [W-1:0]       rem_q, rem_d;
   logic [W-1:0]       step_val;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  cap_q, cap_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               crc_err_q, crc_err_d;

   // One division step: subtract the generator aligned under bit idx when that bit is set.
   always_comb begin
      step_val = rem_q;
      if (rem_q[idx_q]) begin
         step_val = rem_q ^ (GEN_W << (idx_q - IDX_W'(CRC_W)));
      end
   end

   // Checker sequencing; results are latched on the last step so they
   // appear together with done.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      cap_d     = cap_q;
      data_d    = data_q;
      crc_err_d = crc_err_q;
      case (state_q)
         C_IDLE, C_DONE: begin
            state_d = C_IDLE;
            if (start_i) begin
               rem_d   = codeword_i;
               cap_d   = codeword_i[W-1:CRC_W];
               idx_d   = IDX_W'(W - 1);
               state_d = C_RUN;
            end
         end
         C_RUN: begin
            rem_d = step_val;
            idx_d = idx_q - IDX_W'(1);
            if (idx_q == IDX_W'(CRC_W)) begin
               state_d   = C_DONE;
               data_d    = cap_q;
               crc_err_d = |step_val[CRC_W-1:0];
            end
         end
         default: state_d = C_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= C_IDLE;
         rem_q     <= '0;
         idx_q     <= '0;
         cap_q     <= '0;
         data_q    <= '0;
         crc_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         idx_q     <= idx_d;
         cap_q     <= cap_d;
         data_q    <= data_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign done_o    = (state_q == C_DONE);
   assign busy_o    = (state_q != C_IDLE);
   assign data_o    = data_q;
   assign crc_err_o = crc_err_q;

   // The receive side must never hand over a codeword while a division is running.
   a_no_start_in_run: assert property (@(posedge clk) disable iff (rst)
      !(start_i && state_q == C_RUN));

endmodule

// File: rtl/spi_slave_crc_rx.sv
// Oversampling SPI receive slave: collects DATA_W+CRC_W bit codewords and
// hands each one to a serial CRC checker while the next frame streams in.
//
// state   | meaning
// R_IDLE  | cs inactive, waiting for cs low
// R_SHIFT | collecting codeword bits on sample edges
// R_WAIT  | full codeword taken, ignoring sclk until cs rises
module spi_slave_crc_rx
   import spi_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter int               CRC_W     = 4,
   parameter logic [CRC_W-1:0] POLY      = DEFAULT_CRC4_POLY,
   parameter bit               CPOL      = 1'b0,
   parameter bit               CPHA      = 1'b1,
   parameter bit               LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              crc_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int W           = DATA_W + CRC_W;
   localparam int CNT_W       = $clog2(W);
   localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   logic [1:0]       sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic             sclk_prev_q;
   logic             sclk_s, cs_s, mosi_s, sample_edge;

   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;
   logic [W-1:0]     shift_q, shift_d;
   logic             start, frame_err_q, frame_err_d;
   logic             chk_busy;

   // Two-flop synchronisers plus one extra sclk stage for edge detection.
   // Reset values match the idle bus so leaving reset does not fake an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= {2{CPOL}};
         cs_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b00;
         sclk_prev_q <= CPOL;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], sclk};
         cs_sync_q   <= {cs_sync_q[0], cs};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
         sclk_prev_q <= sclk_sync_q[1];
      end
   end

   assign sclk_s      = sclk_sync_q[1];
   assign cs_s        = cs_sync_q[1];
   assign mosi_s      = mosi_sync_q[1];
   assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);

   // Receive sequencing; the W-th bit is merged combinationally so the
   // checker is loaded in the same cycle that bit is sampled.
   always_comb begin
      rx_state_d  = rx_state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      start       = 1'b0;
      frame_err_d = 1'b0;
      wr_idx      = LSB_FIRST ? cnt_q : (CNT_W'(W - 1) - cnt_q);
      case (rx_state_q)
         R_IDLE: begin
            if (!cs_s) begin
               rx_state_d = R_SHIFT;
               cnt_d      = '0;
               shift_d    = '0;
            end
         end
         R_SHIFT: begin
            if (cs_s) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               rx_state_d  = R_IDLE;
            end else if (sample_edge) begin
               shift_d[wr_idx] = mosi_s;
               cnt_d           = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(W - 1)) begin
                  start      = 1'b1;
                  rx_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (cs_s) begin
               rx_state_d = R_IDLE;
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // Receive state, bit counter, shift register and frame error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q  <= R_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   crc_div_serial #(
      .W     (W),
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_crc_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .codeword_i (shift_d),
      .done_o     (valid),
      .busy_o     (chk_busy),
      .data_o     (data),
      .crc_err_o  (crc_err)
   );

   assign frame_err = frame_err_q;
   assign busy      = (rx_state_q != R_IDLE) | chk_busy;

endmodule

// File: tb/tb_spi_slave_crc_rx.sv
// Bench for spi_slave_crc_rx: one default instance (8+4, CPOL0/CPHA1,
// LSB first) and four 16+8 MSB-first instances covering every SPI mode.
module tb_spi_slave_crc_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  sclk_v = 5'b11000;
   logic [4:0]  cs_v   = 5'b11111;
   logic [4:0]  mosi_v = 5'b00000;
   logic [4:0]  valid_v, crc_err_v, ferr_v, busy_v;
   logic [7:0]  data0;
   logic [15:0] data_m [4];

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;
   int vcount    [5] = '{default: 0};
   int fcount    [5] = '{default: 0};
   int last_vcyc [5] = '{default: 0};
   logic [15:0] last_data [5];
   logic        last_err  [5];
   logic [15:0] hist_data [$];
   logic        hist_err  [$];

   typedef struct {
      logic [11:0] cw;
      logic [7:0]  exp_data;
      logic        exp_err;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_slave_crc_rx u_dut (
      .clk(clk), .rst(rst), .sclk(sclk_v[0]), .cs(cs_v[0]), .mosi(mosi_v[0]),
      .data(data0), .valid(valid_v[0]), .crc_err(crc_err_v[0]),
      .frame_err(ferr_v[0]), .busy(busy_v[0]));

   for (genvar g = 0; g < 4; g++) begin : g_mode
      spi_slave_crc_rx #(
         .DATA_W(16), .CRC_W(8), .POLY(8'h07),
         .CPOL(bit'(g / 2)), .CPHA(bit'(g % 2)), .LSB_FIRST(1'b0)
      ) u_dut (
         .clk(clk), .rst(rst), .sclk(sclk_v[g+1]), .cs(cs_v[g+1]), .mosi(mosi_v[g+1]),
         .data(data_m[g]), .valid(valid_v[g+1]), .crc_err(crc_err_v[g+1]),
         .frame_err(ferr_v[g+1]), .busy(busy_v[g+1]));
   end

   // Output monitor: records every valid and counts frame_err cycles.
   always @(negedge clk) begin
      for (int d = 0; d < 5; d++) begin
         if (valid_v[d] === 1'b1) begin
            vcount[d]++;
            last_vcyc[d] = cyc;
            last_err[d]  = crc_err_v[d];
            last_data[d] = (d == 0) ? {8'h00, data0} : data_m[d-1];
            if (d == 0) begin
               hist_data.push_back({8'h00, data0});
               hist_err.push_back(crc_err_v[0]);
            end
         end
         if (ferr_v[d] === 1'b1) fcount[d]++;
      end
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int cfg_dw(input int d);
      return (d == 0) ? 8 : 16;
   endfunction

   function automatic int cfg_cw(input int d);
      return (d == 0) ? 4 : 8;
   endfunction

   function automatic logic [15:0] cfg_poly(input int d);
      return (d == 0) ? 16'h0003 : 16'h0007;
   endfunction

   function automatic bit cfg_cpha(input int d);
      return (d == 0) ? 1'b1 : bit'((d - 1) % 2);
   endfunction

   // GF(2) remainder of a w-bit polynomial by x^k + poly, using the
   // running-remainder register: r = (r*x + next_bit) mod G.
   function automatic logic [31:0] gf2_rem(input logic [31:0] cw, input int w,
                                           input int k, input logic [15:0] poly);
      logic [15:0] r;
      logic        fb;
      r = '0;
      for (int i = w - 1; i >= 0; i--) begin
         fb = r[k-1];
         r  = (r << 1) | 16'(cw[i]);
         if (fb) r = r ^ poly;
         r = r & 16'((32'd1 << k) - 1);
      end
      return 32'(r);
   endfunction

   function automatic logic [31:0] good_cw(input int d, input logic [31:0] dat);
      int          k;
      logic [31:0] m;
      k = cfg_cw(d);
      m = (dat & ((32'd1 << cfg_dw(d)) - 1)) << k;
      return m | gf2_rem(m, cfg_dw(d) + k, k, cfg_poly(d));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic wait_count(input int d, input int target, input int budget);
      int k;
      k = 0;
      while (vcount[d] < target && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Drives n bits of cw with cs already low; returns the cycle of the last sample edge.
   task automatic send_bits(input int d, input logic [31:0] cw, input int n, output int edge_cyc);
      int w;
      w = cfg_dw(d) + cfg_cw(d);
      edge_cyc = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mosi_v[d] = (d == 0) ? cw[i] : cw[w-1-i];
         repeat (3) @(negedge clk);
         sclk_v[d] = ~sclk_v[d];
         if (!cfg_cpha(d)) edge_cyc = cyc;
         repeat (3) @(negedge clk);
         sclk_v[d] = ~sclk_v[d];
         if (cfg_cpha(d)) edge_cyc = cyc;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic send_frame(input int d, input logic [31:0] cw, input int gap, output int edge_cyc);
      @(negedge clk);
      cs_v[d] = 1'b0;
      repeat (2) @(negedge clk);
      send_bits(d, cw, cfg_dw(d) + cfg_cw(d), edge_cyc);
      repeat (2) @(negedge clk);
      cs_v[d] = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   // Sends one frame and checks it against the model.
   task automatic run_frame(input int d, input logic [31:0] cw, input string tag);
      int          v0, f0, ec, k;
      logic [31:0] exp_d;
      logic        exp_e;
      v0    = vcount[d];
      f0    = fcount[d];
      k     = cfg_cw(d);
      exp_d = (cw >> k) & ((32'd1 << cfg_dw(d)) - 1);
      exp_e = (gf2_rem(cw, cfg_dw(d) + k, k, cfg_poly(d)) != 0);
      send_frame(d, cw, 4, ec);
      wait_count(d, v0 + 1, 200);
      chk({tag, "_valid"}, vcount[d], v0 + 1);
      chk({tag, "_data"}, 32'(last_data[d]), exp_d);
      chk({tag, "_crc_err"}, 32'(last_err[d]), 32'(exp_e));
      chk({tag, "_latency"}, last_vcyc[d] - ec, cfg_dw(d) + 3);
      chk({tag, "_no_frame_err"}, fcount[d], f0);
   endtask

   initial begin
      int          ec, v0, f0, n0, d, w;
      logic [7:0]  exp_last_data;
      logic        exp_last_err;
      logic [31:0] cw;

      vecs[0] = '{12'hA5F, 8'hA5, 1'b1};
      vecs[1] = '{12'hA5E, 8'hA5, 1'b1};
      vecs[2] = '{12'hA5B, 8'hA5, 1'b0};
      vecs[3] = '{12'h013, 8'h01, 1'b0};
      vecs[4] = '{12'h001, 8'h00, 1'b1};
      vecs[5] = '{12'h000, 8'h00, 1'b0};
      exp_last_data = 8'h00;
      exp_last_err  = 1'b0;

      // Reset state
      repeat (4) @(negedge clk);
      chk("rst_data", 32'(data0), 0);
      chk("rst_valid", 32'(valid_v[0]), 0);
      chk("rst_crc_err", 32'(crc_err_v[0]), 0);
      chk("rst_frame_err", 32'(ferr_v[0]), 0);
      chk("rst_busy", 32'(busy_v[0]), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Fixed vectors on the default instance
      for (int i = 0; i < 6; i++) begin
         v0 = vcount[0];
         send_frame(0, 32'(vecs[i].cw), 4, ec);
         wait_count(0, v0 + 1, 200);
         chk($sformatf("vec%0d_valid", i), vcount[0], v0 + 1);
         chk($sformatf("vec%0d_data", i), 32'(last_data[0]), 32'(vecs[i].exp_data));
         chk($sformatf("vec%0d_crc_err", i), 32'(last_err[0]), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_latency", i), last_vcyc[0] - ec, 11);
         exp_last_data = vecs[i].exp_data;
         exp_last_err  = vecs[i].exp_err;
      end
      chk("vec_no_frame_err", fcount[0], 0);

      // Truncated frame: cs raised after 7 bits
      v0 = vcount[0];
      f0 = fcount[0];
      @(negedge clk);
      cs_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      send_bits(0, 32'hFFF, 7, ec);
      repeat (2) @(negedge clk);
      cs_v[0] = 1'b1;
      repeat (10) @(negedge clk);
      chk("trunc_frame_err_pulse", fcount[0], f0 + 1);
      chk("trunc_no_valid", vcount[0], v0);
      chk("trunc_data_held", 32'(data0), 32'(exp_last_data));
      chk("trunc_crc_err_held", 32'(crc_err_v[0]), 32'(exp_last_err));
      chk("trunc_idle", 32'(busy_v[0]), 0);
      run_frame(0, good_cw(0, 32'($urandom)), "after_trunc");

      // Back-to-back frames with the minimum cs-high gap
      v0 = vcount[0];
      n0 = hist_data.size();
      send_frame(0, good_cw(0, 32'hA5), 1, ec);
      send_frame(0, 32'hA5F, 1, ec);
      wait_count(0, v0 + 2, 300);
      chk("b2b_valid_count", vcount[0], v0 + 2);
      if (hist_data.size() < n0 + 2) begin
         n_chk++;
         $display("FAIL b2b_history: got %0d records, want %0d", hist_data.size() - n0, 2);
      end else begin
         chk("b2b_first_data", 32'(hist_data[n0]), 32'hA5);
         chk("b2b_first_crc_err", 32'(hist_err[n0]), 0);
         chk("b2b_second_data", 32'(hist_data[n0+1]), 32'hA5);
         chk("b2b_second_crc_err", 32'(hist_err[n0+1]), 1);
      end

      // All four SPI modes, 16+8 MSB first
      for (int m = 1; m <= 4; m++) begin
         run_frame(m, good_cw(m, 32'hC3A5), $sformatf("mode%0d_good", m - 1));
      end

      // Randomized frames across all instances, some with one flipped bit
      for (int i = 0; i < 20; i++) begin
         d  = int'($urandom_range(0, 4));
         w  = cfg_dw(d) + cfg_cw(d);
         cw = good_cw(d, 32'($urandom));
         if ($urandom_range(0, 1) == 1) cw = cw ^ (32'd1 << $urandom_range(0, w - 1));
         run_frame(d, cw, $sformatf("rand%0d_dut%0d", i, d));
      end

      // Reset in the middle of a frame (after 5 bits)
      v0 = vcount[0];
      f0 = fcount[0];
      @(negedge clk);
      cs_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      send_bits(0, good_cw(0, 32'h5A), 5, ec);
      chk("midframe_busy", 32'(busy_v[0]), 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midframe_rst_data", 32'(data0), 0);
      chk("midframe_rst_crc_err", 32'(crc_err_v[0]), 0);
      chk("midframe_rst_busy", 32'(busy_v[0]), 0);
      cs_v[0] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("midframe_no_valid", vcount[0], v0);
      chk("midframe_no_frame_err", fcount[0], f0);
      run_frame(0, good_cw(0, 32'h3C), "after_midframe_rst");

      // Reset while the checker is running
      v0 = vcount[0];
      f0 = fcount[0];
      @(negedge clk);
      cs_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      send_bits(0, good_cw(0, 32'h77), 12, ec);
      repeat (3) @(negedge clk);
      chk("midcheck_busy", 32'(busy_v[0]), 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midcheck_rst_data", 32'(data0), 0);
      chk("midcheck_rst_valid", 32'(valid_v[0]), 0);
      chk("midcheck_rst_busy", 32'(busy_v[0]), 0);
      cs_v[0] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("midcheck_no_valid", vcount[0], v0);
      chk("midcheck_no_frame_err", fcount[0], f0);
      run_frame(0, 32'hA5F, "after_midcheck_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
